// File: rtl/mux16_rr_arbiter_pkg.sv
// Shared types and sizes for the 16-way round-robin mux arbiter.
package mux16_arb_pkg;
    localparam int N_REQ = 16;
    localparam int SEL_W = 4;

    typedef enum logic {IDLE, GRANT} arb_state_t;
    typedef logic [N_REQ-1:0] req_vec_t;
endpackage

// File: rtl/mux16_rr_arbiter_if.sv
// Requester-side bundle: request vector in, registered one-hot grant and mux select out.
interface mux16_rr_arbiter_if;
    import mux16_arb_pkg::*;

    req_vec_t           req;
    req_vec_t           grant;
    logic [SEL_W-1:0]   sel;
    logic               gnt_valid;

    modport master (output req, input grant, input sel, input gnt_valid);
    modport slave  (input req, output grant, output sel, output gnt_valid);
endinterface

// File: rtl/mux16_rr_arbiter_rr_pick16.sv
// Combinational round-robin picker: first eligible request at or after start, wrapping mod 16.
// Rotates so start lands at bit 0, takes the lowest set bit, then adds start back.
module rr_pick16
    import mux16_arb_pkg::*;
(
    input  req_vec_t           req,
    input  logic [SEL_W-1:0]   start,
    input  req_vec_t           excl,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);
    req_vec_t         cand;
    req_vec_t         rot;
    logic [SEL_W-1:0] off;

    always_comb begin
        cand  = req & ~excl;
        rot   = req_vec_t'({cand, cand} >> start);
        found = |rot;
        off   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = SEL_W'(i);
        end
        idx = start + off;
    end
endmodule

// File: rtl/mux16_rr_arbiter.sv
// Round-robin owner of the shared mux16_1 select; one-cycle grant latency, owner bounded to MAX_HOLD cycles under contention.
// All outputs registered; sel feeds the mux select port directly.
module mux16_rr_arbiter
    import mux16_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
)(
    input  logic                clk,
    input  logic                reset,
    mux16_rr_arbiter_if.slave   arb
);
    localparam int HC_W = $clog2(MAX_HOLD + 1);
    localparam logic [HC_W-1:0] HOLD_MAX = HC_W'(MAX_HOLD);
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    logic [0:0]        state_q, state_d;
    req_vec_t          grant_q, grant_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              gnt_valid_q, gnt_valid_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [HC_W-1:0]   hold_cnt_q, hold_cnt_d;

    logic              pick_found;
    logic [SEL_W-1:0]  pick_idx;
    logic              owner_req;
    logic              others_req;
    logic              take;

    // Excluding grant_q is a no-op in IDLE since grant is zero there.
    rr_pick16 u_pick (
        .req   (arb.req),
        .start (ptr_q),
        .excl  (grant_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        sel_d       = sel_q;
        gnt_valid_d = gnt_valid_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        take        = 1'b0;
        owner_req   = |(arb.req & grant_q);
        others_req  = |(arb.req & ~grant_q);

        case (state_q)
            S_IDLE: begin
                take = pick_found;
            end
            default: begin
                if (!owner_req) begin
                    if (pick_found) begin
                        take = 1'b1;
                    end else begin
                        state_d     = S_IDLE;
                        grant_d     = '0;
                        gnt_valid_d = 1'b0;
                        hold_cnt_d  = '0;
                    end
                end else if (hold_cnt_q == HOLD_MAX && others_req) begin
                    take = 1'b1;
                end else if (hold_cnt_q != HOLD_MAX) begin
                    hold_cnt_d = hold_cnt_q + HC_W'(1);
                end
            end
        endcase

        if (take) begin
            state_d     = S_GRANT;
            grant_d     = req_vec_t'(1) << pick_idx;
            sel_d       = pick_idx;
            gnt_valid_d = 1'b1;
            ptr_d       = pick_idx + SEL_W'(1);
            hold_cnt_d  = HC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            sel_q       <= '0;
            gnt_valid_q <= 1'b0;
            ptr_q       <= '0;
            hold_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            sel_q       <= sel_d;
            gnt_valid_q <= gnt_valid_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    assign arb.grant     = grant_q;
    assign arb.sel       = sel_q;
    assign arb.gnt_valid = gnt_valid_q;
endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Bench for mux16_rr_arbiter: directed scenarios plus a sparse random phase, checked every cycle against an owner/ptr model.
module tb_mux16_rr_arbiter;
    import mux16_arb_pkg::*;

    localparam int MAX_HOLD = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mux16_rr_arbiter_if arb_if ();

    mux16_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .reset (reset),
        .arb   (arb_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: owner index (-1 = nobody), cycles owned, next-scan start.
    int m_owner = -1;
    int m_hold  = 0;
    int m_ptr   = 0;
    bit m_init  = 1'b0;
    bit m_sel_zero = 1'b0;

    function automatic int scan(input logic [15:0] r, input int p, input int excl);
        for (int k = 0; k < 16; k++) begin
            int j;
            j = (p + k) % 16;
            if (r[j] && j != excl) return j;
        end
        return -1;
    endfunction

    always @(posedge clk) begin : model
        logic [15:0] r;
        int w;
        r = arb_if.req;
        w = -1;
        if (!reset) begin
            m_owner = -1; m_hold = 0; m_ptr = 0; m_init = 1'b1; m_sel_zero = 1'b1;
        end else if (m_init) begin
            if (m_owner < 0) begin
                w = scan(r, m_ptr, -1);
            end else if (!r[m_owner]) begin
                w = scan(r, m_ptr, m_owner);
                if (w < 0) begin
                    m_owner = -1;
                    m_hold  = 0;
                end
            end else if (m_hold == MAX_HOLD && (r & ~(16'd1 << m_owner)) != 16'd0) begin
                w = scan(r, m_ptr, m_owner);
            end else if (m_hold < MAX_HOLD) begin
                m_hold = m_hold + 1;
            end
            if (w >= 0) begin
                m_owner = w; m_hold = 1; m_ptr = (w + 1) % 16; m_sel_zero = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("grant", 32'(arb_if.grant), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
            chk("gnt_valid", 32'(arb_if.gnt_valid), (m_owner >= 0) ? 32'd1 : 32'd0);
            chk("onehot0", 32'($onehot0(arb_if.grant)), 32'd1);
            if (m_owner >= 0) chk("sel", 32'(arb_if.sel), 32'(m_owner));
            else if (m_sel_zero) chk("sel_reset", 32'(arb_if.sel), 32'd0);
        end
    end

    initial begin
        reset = 1'b0;
        arb_if.req = 16'hFFFF;
        repeat (2) begin
            @(negedge clk);
            chk("t1_grant", 32'(arb_if.grant), 32'd0);
            chk("t1_sel", 32'(arb_if.sel), 32'd0);
            chk("t1_valid", 32'(arb_if.gnt_valid), 32'd0);
        end

        reset = 1'b1;
        arb_if.req = 16'h0010;
        @(negedge clk);
        chk("t2_grant", 32'(arb_if.grant), 32'h0010);
        chk("t2_sel", 32'(arb_if.sel), 32'd4);
        chk("t2_valid", 32'(arb_if.gnt_valid), 32'd1);
        arb_if.req = 16'h0000;
        @(negedge clk);
        chk("t2_idle_grant", 32'(arb_if.grant), 32'd0);
        chk("t2_idle_valid", 32'(arb_if.gnt_valid), 32'd0);

        reset = 1'b0;
        arb_if.req = 16'hFFFF;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("t3_rotate_sel", 32'(arb_if.sel), 32'(i / 8));
        end

        arb_if.req = 16'h0008;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("t4_alone_sel", 32'(arb_if.sel), 32'd3);
        end
        arb_if.req = 16'h0208;
        @(negedge clk);
        chk("t4_preempt_sel", 32'(arb_if.sel), 32'd9);

        arb_if.req = 16'h8000;
        @(negedge clk);
        chk("t5_sel15", 32'(arb_if.sel), 32'd15);
        arb_if.req = 16'h8001;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("t5_hold15", 32'(arb_if.sel), 32'd15);
        end
        @(negedge clk);
        chk("t5_wrap_sel", 32'(arb_if.sel), 32'd0);

        arb_if.req = 16'h0040;
        @(negedge clk);
        chk("t6_sel6", 32'(arb_if.sel), 32'd6);
        reset = 1'b0;
        arb_if.req = 16'h00C0;
        @(negedge clk);
        chk("t6_rst_grant", 32'(arb_if.grant), 32'd0);
        chk("t6_rst_valid", 32'(arb_if.gnt_valid), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_after_sel", 32'(arb_if.sel), 32'd6);
        chk("t6_after_grant", 32'(arb_if.grant), 32'h0040);

        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0)
                arb_if.req = 16'($urandom) & 16'($urandom) & 16'($urandom);
            reset = ($urandom_range(0, 59) != 0);
        end
        reset = 1'b1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
